div_unit: RTL and testbench



---
 rtl/div_unit.sv | 144 ++++++++++++++
 tb/tb_div_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Result is {remainder (HI), quotient (LO)}; stall_o holds the pipeline while dividing.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic                 annul_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stall_o
);

   typedef enum logic [1:0] {
      IDLE,
      DZ,
      ON,
      END
   } state_e;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     div_q, div_d;
   logic [WIDTH-1:0]     opa_q, opa_d;
   logic                 negQuo_q, negQuo_d;
   logic                 negRem_q, negRem_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic [WIDTH-1:0]     absA;
   logic [WIDTH-1:0]     absB;
   logic [WIDTH+1:0]     trial;
   logic [WIDTH:0]       remStep;
   logic [WIDTH-1:0]     quoStep;
   logic [WIDTH-1:0]     quoFinal;
   logic [WIDTH-1:0]     remFinal;

   // One restoring step: shift {rem,quo} left and keep the subtraction if it did not borrow.
   always_comb begin
      absA = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      absB = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      trial = {rem_q, quo_q[WIDTH-1]} - {2'b00, div_q};
      if (trial[WIDTH+1]) begin
         remStep = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      end else begin
         remStep = trial[WIDTH:0];
      end
      quoStep  = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
      quoFinal = negQuo_q ? -quoStep : quoStep;
      remFinal = negRem_q ? -remStep[WIDTH-1:0] : remStep[WIDTH-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      div_d    = div_q;
      opa_d    = opa_q;
      negQuo_d = negQuo_q;
      negRem_d = negRem_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               opa_d    = opdata1_i;
               div_d    = absB;
               rem_d    = '0;
               quo_d    = absA;
               cnt_d    = '0;
               negQuo_d = signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               negRem_d = signed_i && opdata1_i[WIDTH-1];
               state_d  = (opdata2_i == '0) ? DZ : ON;
            end
         end
         ON: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               rem_d = remStep;
               quo_d = quoStep;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  result_d = {remFinal, quoFinal};
                  state_d  = END;
               end
            end
         end
         // Divide by zero reports the raw dividend as remainder, without sign fixup.
         DZ: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               result_d = {opa_q, {WIDTH{1'b1}}};
               state_d  = END;
            end
         end
         END: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         div_q    <= '0;
         opa_q    <= '0;
         negQuo_q <= 1'b0;
         negRem_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         div_q    <= div_d;
         opa_q    <= opa_d;
         negQuo_q <= negQuo_d;
         negRem_q <= negRem_d;
         result_q <= result_d;
      end
   end

   // The stall drops in END so the pipeline advances in the cycle it captures HI/LO.
   assign stall_o  = !annul_i && (((state_q == IDLE) && start_i) || (state_q == ON) || (state_q == DZ));
   assign ready_o  = (state_q == END);
   assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: timing of stall/ready, signed/unsigned
// results, divide by zero, annul, operand hold and mid-operation reset.
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic        annul;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [63:0] result;
   logic        ready;
   logic        stall;

   int compared;
   int mismatched;

   div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .signed_i  (sgn),
      .annul_i   (annul),
      .opdata1_i (op1),
      .opdata2_i (op2),
      .result_o  (result),
      .ready_o   (ready),
      .stall_o   (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
      nextCycle();
      nextCycle();
      rst = 1'b0;
      #1;
      compared++;
      if (result !== 64'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_result got=%h exp=%h", result, 64'h0);
      end
      compared++;
      if (ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ready got=%b exp=0", ready);
      end
      compared++;
      if (stall !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_stall got=%b exp=0", stall);
      end
   endtask

   task automatic test_divu_basic();
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
      #1;
      compared++;
      if (stall !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_stall_t got=%b exp=1", stall);
      end
      for (int k = 1; k <= 32; k++) begin
         nextCycle();
         start = 1'b0;
         #1;
         compared++;
         if (stall !== 1'b1 || ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_busy cycle=%0d got stall=%b ready=%b exp stall=1 ready=0", k, stall, ready);
         end
      end
      nextCycle();
      #1;
      compared++;
      if (stall !== 1'b0 || ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_end got stall=%b ready=%b exp stall=0 ready=1", stall, ready);
      end
      compared++;
      if (result !== {32'd2, 32'd14}) begin
         mismatched++;
         $display("[TB] FAIL basic_result got=%h exp=%h", result, {32'd2, 32'd14});
      end
      nextCycle();
      #1;
      compared++;
      if (ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_ready_pulse got=%b exp=0", ready);
      end
   endtask

   task automatic test_signed();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic        vs [7];
      logic [63:0] ve [7];
      int          cycles;
      va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        vs[0] = 1'b1; ve[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
      va[1] = 32'h7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1; ve[1] = {32'h00000001, 32'hFFFFFFFD};
      va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vs[2] = 1'b1; ve[2] = {32'h00000000, 32'h80000000};
      va[3] = 32'hFFFFFFF9; vb[3] = 32'h2;        vs[3] = 1'b0; ve[3] = {32'h00000001, 32'h7FFFFFFC};
      va[4] = 32'hFFFFFFFF; vb[4] = 32'h10;       vs[4] = 1'b0; ve[4] = {32'h0000000F, 32'h0FFFFFFF};
      va[5] = 32'hFFFFFF9C; vb[5] = 32'hFFFFFFF9; vs[5] = 1'b1; ve[5] = {32'hFFFFFFFE, 32'h0000000E};
      va[6] = 32'h3;        vb[6] = 32'h7;        vs[6] = 1'b0; ve[6] = {32'h00000003, 32'h00000000};
      for (int i = 0; i < 7; i++) begin
         nextCycle();
         start = 1'b1; sgn = vs[i]; op1 = va[i]; op2 = vb[i];
         cycles = 0;
         for (int k = 1; k <= 40; k++) begin
            nextCycle();
            start = 1'b0;
            #1;
            if (ready === 1'b1) begin
               cycles = k;
               break;
            end
         end
         compared++;
         if (cycles != 33) begin
            mismatched++;
            $display("[TB] FAIL signed_latency vec=%0d got=%0d exp=33", i, cycles);
         end
         compared++;
         if (result !== ve[i]) begin
            mismatched++;
            $display("[TB] FAIL signed_result vec=%0d got=%h exp=%h", i, result, ve[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd5; op2 = 32'd0;
      #1;
      compared++;
      if (stall !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL dz_stall_t got=%b exp=1", stall);
      end
      nextCycle();
      start = 1'b0;
      #1;
      compared++;
      if (stall !== 1'b1 || ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL dz_t1 got stall=%b ready=%b exp stall=1 ready=0", stall, ready);
      end
      nextCycle();
      #1;
      compared++;
      if (stall !== 1'b0 || ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL dz_t2 got stall=%b ready=%b exp stall=0 ready=1", stall, ready);
      end
      compared++;
      if (result !== {32'd5, 32'hFFFFFFFF}) begin
         mismatched++;
         $display("[TB] FAIL dz_result got=%h exp=%h", result, {32'd5, 32'hFFFFFFFF});
      end
      nextCycle();
      start = 1'b1; sgn = 1'b1; op1 = 32'hFFFFFFF8; op2 = 32'd0;
      nextCycle();
      start = 1'b0;
      nextCycle();
      #1;
      compared++;
      if (ready !== 1'b1 || result !== {32'hFFFFFFF8, 32'hFFFFFFFF}) begin
         mismatched++;
         $display("[TB] FAIL dz_signed got ready=%b result=%h exp ready=1 result=%h", ready, result, {32'hFFFFFFF8, 32'hFFFFFFFF});
      end
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd9; op2 = 32'd0;
      nextCycle();
      start = 1'b0; annul = 1'b1;
      #1;
      compared++;
      if (stall !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL dz_annul_stall got=%b exp=0", stall);
      end
      nextCycle();
      annul = 1'b0;
      #1;
      compared++;
      if (ready !== 1'b0 || stall !== 1'b0 || result !== {32'hFFFFFFF8, 32'hFFFFFFFF}) begin
         mismatched++;
         $display("[TB] FAIL dz_annul_after got ready=%b stall=%b result=%h exp ready=0 stall=0 result=%h", ready, stall, result, {32'hFFFFFFF8, 32'hFFFFFFFF});
      end
   endtask

   task automatic test_annul_back_to_back();
      logic [63:0] prior;
      prior = {32'hFFFFFFF8, 32'hFFFFFFFF};
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
      for (int k = 1; k <= 9; k++) begin
         nextCycle();
         start = 1'b0;
      end
      nextCycle();
      annul = 1'b1;
      #1;
      compared++;
      if (stall !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL annul_stall got=%b exp=0", stall);
      end
      nextCycle();
      annul = 1'b0;
      #1;
      compared++;
      if (stall !== 1'b0 || ready !== 1'b0 || result !== prior) begin
         mismatched++;
         $display("[TB] FAIL annul_idle got stall=%b ready=%b result=%h exp stall=0 ready=0 result=%h", stall, ready, result, prior);
      end
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
      #1;
      compared++;
      if (stall !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL b2b_stall_start got=%b exp=1", stall);
      end
      for (int k = 13; k <= 44; k++) begin
         nextCycle();
         start = 1'b0;
         #1;
         compared++;
         if (ready !== 1'b0 || result !== prior) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy cycle=%0d got ready=%b result=%h exp ready=0 result=%h", k, ready, result, prior);
         end
      end
      nextCycle();
      start = 1'b1; op1 = 32'd50; op2 = 32'd5;
      #1;
      compared++;
      if (ready !== 1'b1 || stall !== 1'b0 || result !== {32'd1, 32'd333}) begin
         mismatched++;
         $display("[TB] FAIL b2b_end got ready=%b stall=%b result=%h exp ready=1 stall=0 result=%h", ready, stall, result, {32'd1, 32'd333});
      end
      nextCycle();
      start = 1'b0;
      #1;
      compared++;
      if (stall !== 1'b0 || ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL end_start_ignored got stall=%b ready=%b exp stall=0 ready=0", stall, ready);
      end
   endtask

   task automatic test_hold_and_reset();
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
      for (int k = 1; k <= 32; k++) begin
         nextCycle();
         start = (k % 3 == 0);
         sgn = k[0];
         op1 = 32'hDEAD0000 + k;
         op2 = (k % 4 == 0) ? 32'd0 : 32'h13;
      end
      nextCycle();
      start = 1'b0;
      #1;
      compared++;
      if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
         mismatched++;
         $display("[TB] FAIL hold_result got ready=%b result=%h exp ready=1 result=%h", ready, result, {32'd2, 32'd14});
      end
      nextCycle();
      start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
      for (int k = 1; k <= 19; k++) begin
         nextCycle();
         start = 1'b0;
      end
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      #1;
      compared++;
      if (result !== 64'h0 || ready !== 1'b0 || stall !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midop_reset got result=%h ready=%b stall=%b exp result=0 ready=0 stall=0", result, ready, stall);
      end
      for (int k = 1; k <= 20; k++) begin
         nextCycle();
         compared++;
         if (ready !== 1'b0 || stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_idle cycle=%0d got ready=%b stall=%b exp 0/0", k, ready, stall);
         end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_annul_back_to_back();
      test_hold_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
